control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 36 +++
 rtl/control_fsm.sv | 139 +++++++++++++
 tb/tb_control_fsm.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm_if
// Description : Instruction fields, memory handshake and decoded controls
//               exchanged between the multicycle datapath and control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_fsm_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  state;
    logic [2:0]  alucont;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        irwrite;
    logic        branch_taken;
    logic        illegal;
    logic [31:0] instret;

    // Datapath side: supplies instruction fields and flags, consumes controls.
    modport master (
        output op, funct, zero, mem_ready,
        input  state, alucont, alusrca, alusrcb, irwrite,
        input  branch_taken, illegal, instret
    );

    // Controller side.
    modport slave (
        input  op, funct, zero, mem_ready,
        output state, alucont, alusrca, alusrcb, irwrite,
        output branch_taken, illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multicycle MIPS-subset controller: sequences fetch/decode/
//               execute, drives ALU selects, counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm #(
    parameter logic [31:0] INSTRET_RESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.slave  bus
);

    localparam logic [5:0] c_OP_R    = 6'b000000;
    localparam logic [5:0] c_OP_LB   = 6'b100000;
    localparam logic [5:0] c_OP_SB   = 6'b101000;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_BEQ  = 6'b000100;
    localparam logic [5:0] c_OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_LBRD    = 4'd3,
        S_SBWR    = 4'd4,
        S_RTYPEEX = 4'd5,
        S_ADDIEX  = 4'd6,
        S_BEQEX   = 4'd7,
        S_JEX     = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_illegal;
    logic [31:0] r_instret;
    logic        w_retire;
    logic        w_illegal_set;
    logic        w_funct_ok;
    logic [2:0]  w_rtype_alu;
    logic [2:0]  w_alucont;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= INSTRET_RESET;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)      r_instret <= r_instret + 32'd1;
            if (w_illegal_set) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_rtype_alu = 3'b010;
        w_funct_ok  = 1'b1;
        case (bus.funct)
            6'b100000: w_rtype_alu = 3'b010;
            6'b100010: w_rtype_alu = 3'b110;
            6'b100100: w_rtype_alu = 3'b000;
            6'b100101: w_rtype_alu = 3'b001;
            6'b101010: w_rtype_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = S_FETCH;
        w_retire      = 1'b0;
        w_illegal_set = 1'b0;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    c_OP_LB, c_OP_SB: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_RTYPEEX;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_BEQ:         w_next = S_BEQEX;
                    c_OP_J:           w_next = S_JEX;
                    default: begin
                        // Undefined opcode is dropped, not retired.
                        w_next        = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (bus.op == c_OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD: begin
                w_next   = bus.mem_ready ? S_FETCH : S_LBRD;
                w_retire = bus.mem_ready;
            end
            S_RTYPEEX: begin
                w_retire      = 1'b1;
                w_illegal_set = ~w_funct_ok;
            end
            S_SBWR, S_ADDIEX, S_BEQEX, S_JEX: w_retire = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_alucont = 3'b010;
        w_alusrca = 1'b0;
        w_alusrcb = 2'b11;
        case (r_state)
            S_MEMADR, S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b00;
                w_alucont = w_rtype_alu;
            end
            S_BEQEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b00;
                w_alucont = 3'b110;
            end
            default: ;
        endcase
    end

    assign bus.state        = r_state;
    assign bus.alucont      = w_alucont;
    assign bus.alusrca      = w_alusrca;
    assign bus.alusrcb      = w_alusrcb;
    assign bus.irwrite      = (r_state == S_FETCH) && bus.mem_ready;
    assign bus.branch_taken = (r_state == S_BEQEX) && bus.zero;
    assign bus.illegal      = r_illegal;
    assign bus.instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm
// Description : Directed, table-driven bench for control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

    localparam logic [5:0] c_R    = 6'b000000;
    localparam logic [5:0] c_LB   = 6'b100000;
    localparam logic [5:0] c_SB   = 6'b101000;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_ADD  = 6'b100000;
    localparam logic [5:0] c_SUB  = 6'b100010;
    localparam logic [5:0] c_AND  = 6'b100100;
    localparam logic [5:0] c_OR   = 6'b100101;
    localparam logic [5:0] c_SLT  = 6'b101010;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    control_fsm_if bus ();
    control_fsm_if bus_w ();

    control_fsm dut (.clk(clk), .reset(reset), .bus(bus));
    control_fsm #(.INSTRET_RESET(32'hFFFF_FFFF)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [2:0]  alu;
        logic        a;
        logic [1:0]  b;
        logic        irw;
        logic        br;
        logic [31:0] ir;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input logic mr, input logic [3:0] st, input logic [2:0] alu,
                       input logic a, input logic [1:0] b, input logic irw,
                       input logic br, input logic [31:0] ir);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.mr = mr; v.st = st; v.alu = alu;
        v.a = a; v.b = b; v.irw = irw; v.br = br; v.ir = ir;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] funct,
                         input logic zero, input logic mr);
        bus.op = op; bus.funct = funct; bus.zero = zero; bus.mem_ready = mr;
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(c_R, 6'd0, 1'b0, 1'b0);
        bus_w.op = c_J; bus_w.funct = 6'd0; bus_w.zero = 1'b0; bus_w.mem_ready = 1'b0;
        #1;
        chk("reset state",   32'(bus.state), 32'd0);
        chk("reset instret", bus.instret, 32'd0);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        chk("reset irwrite", 32'(bus.irwrite), 32'd0);
        chk("reset alusrcb", 32'(bus.alusrcb), 32'd3);
        drive(c_R, 6'd0, 1'b0, 1'b1);
        chk("reset irwrite mr1", 32'(bus.irwrite), 32'd1);

        // lb: 0,1,2,3,3,3,3,0
        add(c_LB, 6'd0, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 0);
        add(c_LB, 6'd0, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 0);
        add(c_LB, 6'd0, 0, 0, 4'd2, 3'b010, 1, 2'b10, 0, 0, 0);
        add(c_LB, 6'd0, 0, 0, 4'd3, 3'b010, 0, 2'b11, 0, 0, 0);
        add(c_LB, 6'd0, 0, 0, 4'd3, 3'b010, 0, 2'b11, 0, 0, 0);
        add(c_LB, 6'd0, 0, 0, 4'd3, 3'b010, 0, 2'b11, 0, 0, 0);
        add(c_LB, 6'd0, 0, 1, 4'd3, 3'b010, 0, 2'b11, 0, 0, 0);
        // sub, entered after one FETCH stall cycle
        add(c_R, c_SUB, 0, 0, 4'd0, 3'b010, 0, 2'b11, 0, 0, 1);
        add(c_R, c_SUB, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 1);
        add(c_R, c_SUB, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 1);
        add(c_R, c_SUB, 0, 0, 4'd5, 3'b110, 1, 2'b00, 0, 0, 1);
        // beq taken then not taken
        add(c_BEQ, 6'd0, 1, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 2);
        add(c_BEQ, 6'd0, 1, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 2);
        add(c_BEQ, 6'd0, 1, 0, 4'd7, 3'b110, 1, 2'b00, 0, 1, 2);
        add(c_BEQ, 6'd0, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 3);
        add(c_BEQ, 6'd0, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 3);
        add(c_BEQ, 6'd0, 0, 0, 4'd7, 3'b110, 1, 2'b00, 0, 0, 3);
        // addi, with mem_ready high in DECODE (no irwrite there)
        add(c_ADDI, 6'd0, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 4);
        add(c_ADDI, 6'd0, 0, 1, 4'd1, 3'b010, 0, 2'b11, 0, 0, 4);
        add(c_ADDI, 6'd0, 0, 0, 4'd6, 3'b010, 1, 2'b10, 0, 0, 4);
        // sb
        add(c_SB, 6'd0, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 5);
        add(c_SB, 6'd0, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 5);
        add(c_SB, 6'd0, 0, 0, 4'd2, 3'b010, 1, 2'b10, 0, 0, 5);
        add(c_SB, 6'd0, 0, 0, 4'd4, 3'b010, 0, 2'b11, 0, 0, 5);
        // j
        add(c_J, 6'd0, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 6);
        add(c_J, 6'd0, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 6);
        add(c_J, 6'd0, 0, 1, 4'd8, 3'b010, 0, 2'b11, 0, 0, 6);
        // remaining funct codes; zero high in RTYPEEX must not set branch_taken
        add(c_R, c_AND, 1, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 7);
        add(c_R, c_AND, 1, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 7);
        add(c_R, c_AND, 1, 0, 4'd5, 3'b000, 1, 2'b00, 0, 0, 7);
        add(c_R, c_OR,  0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 8);
        add(c_R, c_OR,  0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 8);
        add(c_R, c_OR,  0, 0, 4'd5, 3'b001, 1, 2'b00, 0, 0, 8);
        add(c_R, c_SLT, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 9);
        add(c_R, c_SLT, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 9);
        add(c_R, c_SLT, 0, 0, 4'd5, 3'b111, 1, 2'b00, 0, 0, 9);
        add(c_R, c_ADD, 0, 1, 4'd0, 3'b010, 0, 2'b11, 1, 0, 10);
        add(c_R, c_ADD, 0, 0, 4'd1, 3'b010, 0, 2'b11, 0, 0, 10);
        add(c_R, c_ADD, 0, 0, 4'd5, 3'b010, 1, 2'b00, 0, 0, 10);
        // FETCH holds while mem_ready=0
        add(c_R, c_ADD, 1, 0, 4'd0, 3'b010, 0, 2'b11, 0, 0, 11);
        add(c_R, c_ADD, 1, 0, 4'd0, 3'b010, 0, 2'b11, 0, 0, 11);

        nxt();
        reset = 1'b0;
        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].funct, vt[i].zero, vt[i].mr);
            chk($sformatf("row%0d state", i),   32'(bus.state),        32'(vt[i].st));
            chk($sformatf("row%0d alucont", i), 32'(bus.alucont),      32'(vt[i].alu));
            chk($sformatf("row%0d alusrca", i), 32'(bus.alusrca),      32'(vt[i].a));
            chk($sformatf("row%0d alusrcb", i), 32'(bus.alusrcb),      32'(vt[i].b));
            chk($sformatf("row%0d irwrite", i), 32'(bus.irwrite),      32'(vt[i].irw));
            chk($sformatf("row%0d branch", i),  32'(bus.branch_taken), 32'(vt[i].br));
            chk($sformatf("row%0d illegal", i), 32'(bus.illegal),      32'd0);
            chk($sformatf("row%0d instret", i), bus.instret,           vt[i].ir);
            nxt();
        end

        // Undefined opcode: back to FETCH, sticky illegal, no count
        drive(6'b111111, 6'd0, 0, 1); chk("ill fetch", 32'(bus.state), 32'd0); nxt();
        drive(6'b111111, 6'd0, 0, 0); chk("ill decode", 32'(bus.state), 32'd1);
        chk("ill before", 32'(bus.illegal), 32'd0); nxt();
        drive(6'b111111, 6'd0, 0, 0); chk("ill back", 32'(bus.state), 32'd0);
        chk("ill set", 32'(bus.illegal), 32'd1); chk("ill instret", bus.instret, 32'd11);
        drive(c_J, 6'd0, 0, 1); nxt();
        drive(c_J, 6'd0, 0, 0); nxt();
        chk("ill j jex", 32'(bus.state), 32'd8); nxt();
        chk("ill j instret", bus.instret, 32'd12);
        chk("ill sticky", 32'(bus.illegal), 32'd1);

        // Reset clears illegal; then an undefined funct still retires but flags illegal
        reset = 1'b1; #1;
        chk("rst2 illegal", 32'(bus.illegal), 32'd0);
        chk("rst2 instret", bus.instret, 32'd0);
        nxt(); reset = 1'b0;
        drive(c_R, 6'b000000, 0, 1); nxt();
        drive(c_R, 6'b000000, 0, 0); nxt();
        chk("badf state", 32'(bus.state), 32'd5);
        chk("badf alucont", 32'(bus.alucont), 32'd2);
        chk("badf alusrca", 32'(bus.alusrca), 32'd1);
        chk("badf alusrcb", 32'(bus.alusrcb), 32'd0);
        chk("badf ill pre", 32'(bus.illegal), 32'd0); nxt();
        chk("badf ill", 32'(bus.illegal), 32'd1);
        chk("badf instret", bus.instret, 32'd1);

        // Reset asserted mid-cycle during an LBRD stall aborts the load
        drive(c_LB, 6'd0, 0, 1); nxt();
        drive(c_LB, 6'd0, 0, 0); nxt(); nxt();
        chk("lbrd state", 32'(bus.state), 32'd3); nxt();
        chk("lbrd stall", 32'(bus.state), 32'd3);
        #2; reset = 1'b1; #1;
        chk("async state", 32'(bus.state), 32'd0);
        chk("async instret", bus.instret, 32'd0);
        chk("async illegal", 32'(bus.illegal), 32'd0);
        nxt();
        drive(c_LB, 6'd0, 0, 1);
        chk("held irwrite", 32'(bus.irwrite), 32'd1);
        reset = 1'b0; #1;
        chk("post rst state", 32'(bus.state), 32'd0); nxt();
        chk("post rst decode", 32'(bus.state), 32'd1);
        chk("post rst instret", bus.instret, 32'd0);

        // instret wrap on the instance preset to all ones
        bus_w.op = c_J; bus_w.mem_ready = 1'b1; #1;
        chk("wrap pre", bus_w.instret, 32'hFFFF_FFFF);
        chk("wrap fetch", 32'(bus_w.state), 32'd0); nxt();
        bus_w.mem_ready = 1'b0; nxt();
        chk("wrap jex", 32'(bus_w.state), 32'd8); nxt();
        chk("wrap instret", bus_w.instret, 32'd0);
        chk("wrap back", 32'(bus_w.state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
